// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute steps,
// drives every datapath enable and mux select, and counts retired instructions.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  localparam logic [3:0] StFetch   = 4'd0;
  localparam logic [3:0] StDecode  = 4'd1;
  localparam logic [3:0] StMemAddr = 4'd2;
  localparam logic [3:0] StMemRd   = 4'd3;
  localparam logic [3:0] StMemWb   = 4'd4;
  localparam logic [3:0] StMemWr   = 4'd5;
  localparam logic [3:0] StExec    = 4'd6;
  localparam logic [3:0] StRWb     = 4'd7;
  localparam logic [3:0] StBranch  = 4'd8;
  localparam logic [3:0] StJump    = 4'd9;
  localparam logic [3:0] StAddiEx  = 4'd10;
  localparam logic [3:0] StAddiWb  = 4'd11;

  logic [3:0]  state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;
  logic        illegal_raw;
  logic        pc_write_raw, pc_write_cond_raw, ir_write_raw;
  logic        reg_write_raw, mem_write_raw, mem_read_raw;

  always_comb begin
    state_d           = StFetch;
    retire            = 1'b0;
    illegal_raw       = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    mem_write_raw     = 1'b0;
    mem_read_raw      = 1'b0;
    i_or_d            = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'd0;
    alu_op            = 2'd0;
    pc_source         = 2'd0;
    case (state_q)
      StFetch: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'd1;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_d      = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = 2'd3;
        if (opcode == OP_LW || opcode == OP_SW) state_d = StMemAddr;
        else if (opcode == OP_RTYPE)            state_d = StExec;
        else if (opcode == OP_BEQ)              state_d = StBranch;
        else if (opcode == OP_J)                state_d = StJump;
        else if (opcode == OP_ADDI)             state_d = StAddiEx;
        else                                    illegal_raw = 1'b1;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_LW)      state_d = StMemRd;
        else if (opcode == OP_SW) state_d = StMemWr;
      end
      StMemRd: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
        state_d      = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        retire        = 1'b1;
      end
      StMemWr: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
        state_d       = mem_ready ? StFetch : StMemWr;
        retire        = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        retire        = 1'b1;
      end
      StBranch: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'd1;
        pc_write_cond_raw = 1'b1;
        pc_source         = 2'd1;
        retire            = 1'b1;
      end
      StJump: begin
        pc_write_raw = 1'b1;
        pc_source    = 2'd2;
        retire       = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes that could disturb architectural state are suppressed while reset is held.
  assign pc_write      = pc_write_raw      & ~rst;
  assign pc_write_cond = pc_write_cond_raw & ~rst;
  assign ir_write      = ir_write_raw      & ~rst;
  assign reg_write     = reg_write_raw     & ~rst;
  assign mem_write     = mem_write_raw     & ~rst;
  assign mem_read      = mem_read_raw      & ~rst;
  assign illegal_op    = illegal_raw       & ~rst;

  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls and resets.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles
    tick();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    tick();
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h00;
    #1;
    chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_retired", retired, 32'd0);
    chk("fetch_mem_read", 32'(mem_read), 32'd1);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_pc_write", 32'(pc_write), 32'd1);
    chk("fetch_alu_src_b", 32'(alu_src_b), 32'd1);

    // R-type
    tick();
    chk("r_decode", 32'(state), 32'd1);
    chk("r_decode_srcb", 32'(alu_src_b), 32'd3);
    chk("r_decode_irw", 32'(ir_write), 32'd0);
    tick();
    chk("r_exec", 32'(state), 32'd6);
    chk("r_exec_aluop", 32'(alu_op), 32'd2);
    chk("r_exec_regw", 32'(reg_write), 32'd0);
    tick();
    chk("r_wb", 32'(state), 32'd7);
    chk("r_wb_regw", 32'(reg_write), 32'd1);
    chk("r_wb_regdst", 32'(reg_dst), 32'd1);
    tick();
    chk("r_done_state", 32'(state), 32'd0);
    chk("r_done_retired", retired, 32'd1);

    // LW with two stall cycles in MEM_RD
    opcode = 6'h23;
    tick();
    chk("lw_decode", 32'(state), 32'd1);
    tick();
    chk("lw_addr", 32'(state), 32'd2);
    chk("lw_addr_srcb", 32'(alu_src_b), 32'd2);
    chk("lw_addr_srca", 32'(alu_src_a), 32'd1);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_rd", 32'(state), 32'd3);
    chk("lw_rd_memread", 32'(mem_read), 32'd1);
    chk("lw_rd_iord", 32'(i_or_d), 32'd1);
    tick();
    chk("lw_stall1", 32'(state), 32'd3);
    tick();
    chk("lw_stall2", 32'(state), 32'd3);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb", 32'(state), 32'd4);
    chk("lw_wb_regw", 32'(reg_write), 32'd1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_retired", retired, 32'd1);
    tick();
    chk("lw_done", 32'(state), 32'd0);
    chk("lw_retired", retired, 32'd2);

    // SW, BEQ, J back to back
    opcode = 6'h2B;
    tick();
    chk("sw_decode_memw", 32'(mem_write), 32'd0);
    tick();
    chk("sw_addr", 32'(state), 32'd2);
    tick();
    chk("sw_wr", 32'(state), 32'd5);
    chk("sw_wr_memw", 32'(mem_write), 32'd1);
    chk("sw_wr_pcwc", 32'(pc_write_cond), 32'd0);
    tick();
    chk("sw_done", 32'(state), 32'd0);
    opcode = 6'h04;
    tick();
    chk("beq_decode", 32'(state), 32'd1);
    tick();
    chk("beq_state", 32'(state), 32'd8);
    chk("beq_pcwc", 32'(pc_write_cond), 32'd1);
    chk("beq_pcsrc", 32'(pc_source), 32'd1);
    chk("beq_aluop", 32'(alu_op), 32'd1);
    chk("beq_memw", 32'(mem_write), 32'd0);
    tick();
    opcode = 6'h02;
    tick();
    chk("j_decode", 32'(state), 32'd1);
    tick();
    chk("j_state", 32'(state), 32'd9);
    chk("j_pcw", 32'(pc_write), 32'd1);
    chk("j_pcsrc", 32'(pc_source), 32'd2);
    chk("j_pcwc", 32'(pc_write_cond), 32'd0);
    tick();
    chk("sbj_state", 32'(state), 32'd0);
    chk("sbj_retired", retired, 32'd5);

    // Illegal opcode
    opcode = 6'h3F;
    tick();
    chk("ill_decode", 32'(state), 32'd1);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    tick();
    chk("ill_state", 32'(state), 32'd0);
    chk("ill_pulse_gone", 32'(illegal_op), 32'd0);
    chk("ill_retired", retired, 32'd5);

    // ADDI
    opcode = 6'h08;
    tick();
    tick();
    chk("addi_ex", 32'(state), 32'd10);
    chk("addi_ex_srcb", 32'(alu_src_b), 32'd2);
    tick();
    chk("addi_wb", 32'(state), 32'd11);
    chk("addi_wb_regw", 32'(reg_write), 32'd1);
    chk("addi_wb_regdst", 32'(reg_dst), 32'd0);
    tick();
    chk("addi_retired", retired, 32'd6);

    // Fetch stall
    mem_ready = 1'b0;
    #1;
    chk("fstall_irw", 32'(ir_write), 32'd0);
    chk("fstall_pcw", 32'(pc_write), 32'd0);
    tick();
    chk("fstall_state", 32'(state), 32'd0);

    // Reset while stalled in MEM_WR
    opcode = 6'h2B;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    chk("rstwr_state", 32'(state), 32'd5);
    chk("rstwr_memw", 32'(mem_write), 32'd1);
    tick();
    chk("rstwr_stall", 32'(state), 32'd5);
    rst = 1'b1;
    #1;
    chk("rstwr_memw_forced", 32'(mem_write), 32'd0);
    tick();
    chk("rstwr_state0", 32'(state), 32'd0);
    chk("rstwr_retired0", retired, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
